// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: assembles SOF/CMD/ARG/CHK frames, drives the LED register, reports errors.
// Optional acknowledge-byte generation is built when UART_CMD_ACK_EN is defined.
module uart_cmd_parser #(
    parameter logic [7:0]  SOF_BYTE    = 8'h55,
    parameter int unsigned TIMEOUT_CYC = 500_000
) (
    input  logic       clk_50m,
    input  logic       reset_n,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_done,
    output logic [5:0] led,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt,
    output logic [7:0] ack_data,
    output logic       ack_enable
);

    localparam int unsigned      TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ARG,
        S_GET_CHK,
        S_EXEC
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rx_done_d1;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
    logic [7:0]       r_cmd, w_cmd_nxt;
    logic [7:0]       r_arg, w_arg_nxt;
    logic             r_pend, w_pend_nxt;
    logic [7:0]       r_pend_byte, w_pend_byte_nxt;
    logic [5:0]       r_led, w_led_nxt;
    logic             r_cmd_valid, w_cmd_valid_nxt;
    logic [7:0]       r_cmd_code, w_cmd_code_nxt;
    logic [7:0]       r_cmd_arg, w_cmd_arg_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;
    logic [7:0]       r_err_cnt, w_err_cnt_nxt;

    logic             w_byte_stb;
    logic             w_idle_stb;
    logic [7:0]       w_idle_byte;
    logic [7:0]       w_sum;
    logic             w_tmo_hit;

    assign w_byte_stb  = uart_rx_done & ~r_rx_done_d1;
    // A byte caught during EXEC is replayed into IDLE on the next cycle.
    assign w_idle_stb  = w_byte_stb | r_pend;
    assign w_idle_byte = r_pend ? r_pend_byte : uart_rx_data;
    assign w_sum       = r_cmd + r_arg;
    assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_tmo_nxt       = r_tmo_cnt + TMO_W'(1);
        w_cmd_nxt       = r_cmd;
        w_arg_nxt       = r_arg;
        w_pend_nxt      = 1'b0;
        w_pend_byte_nxt = r_pend_byte;
        w_led_nxt       = r_led;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_code_nxt  = r_cmd_code;
        w_cmd_arg_nxt   = r_cmd_arg;
        w_frame_err_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;

        if (w_byte_stb) begin
            w_tmo_nxt = '0;
        end

        case (r_state)
            S_IDLE: begin
                w_tmo_nxt = '0;
                if (w_idle_stb && (w_idle_byte == SOF_BYTE)) begin
                    w_state_nxt = S_GET_CMD;
                end
            end
            S_GET_CMD: begin
                if (w_byte_stb) begin
                    w_cmd_nxt   = uart_rx_data;
                    w_state_nxt = S_GET_ARG;
                end else if (w_tmo_hit) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = 2'b11;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_GET_ARG: begin
                if (w_byte_stb) begin
                    w_arg_nxt   = uart_rx_data;
                    w_state_nxt = S_GET_CHK;
                end else if (w_tmo_hit) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = 2'b11;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_GET_CHK: begin
                if (w_byte_stb) begin
                    if (uart_rx_data == w_sum) begin
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = 2'b01;
                        w_state_nxt     = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = 2'b11;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                if (w_byte_stb) begin
                    w_pend_nxt      = 1'b1;
                    w_pend_byte_nxt = uart_rx_data;
                end
                w_cmd_valid_nxt = 1'b1;
                w_cmd_code_nxt  = r_cmd;
                w_cmd_arg_nxt   = r_arg;
                case (r_cmd)
                    8'h01:   w_led_nxt = r_arg[5:0];
                    8'h02:   w_led_nxt = r_led ^ r_arg[5:0];
                    8'h03:   w_led_nxt = 6'b0;
                    default: begin
                        w_cmd_valid_nxt = 1'b0;
                        w_cmd_code_nxt  = r_cmd_code;
                        w_cmd_arg_nxt   = r_cmd_arg;
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = 2'b10;
                    end
                endcase
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_err_cnt_nxt = r_err_cnt;
        if (w_frame_err_nxt && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rx_done_d1 <= 1'b0;
            r_tmo_cnt    <= '0;
            r_cmd        <= 8'h00;
            r_arg        <= 8'h00;
            r_pend       <= 1'b0;
            r_pend_byte  <= 8'h00;
            r_led        <= 6'h00;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= 8'h00;
            r_cmd_arg    <= 8'h00;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'b00;
            r_err_cnt    <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_done_d1 <= uart_rx_done;
            r_tmo_cnt    <= w_tmo_nxt;
            r_cmd        <= w_cmd_nxt;
            r_arg        <= w_arg_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_byte  <= w_pend_byte_nxt;
            r_led        <= w_led_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_code   <= w_cmd_code_nxt;
            r_cmd_arg    <= w_cmd_arg_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_err_code   <= w_err_code_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign led       = r_led;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_arg   = r_cmd_arg;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign err_cnt   = r_err_cnt;

`ifdef UART_CMD_ACK_EN
    logic       r_ack_en;
    logic [7:0] r_ack_data;

    // Acknowledge follows each command or error strobe by one cycle.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_en   <= 1'b0;
            r_ack_data <= 8'h00;
        end else begin
            r_ack_en <= r_cmd_valid | r_frame_err;
            if (r_frame_err) begin
                r_ack_data <= 8'hE0 | {6'b0, r_err_code};
            end else if (r_cmd_valid) begin
                r_ack_data <= r_cmd_code | 8'h80;
            end
        end
    end

    assign ack_data   = r_ack_data;
    assign ack_enable = r_ack_en;
`else
    assign ack_data   = 8'h00;
    assign ack_enable = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: scoreboard of expected command/error strobes plus per-scenario checks.
module tb_uart_cmd_parser;

    localparam int unsigned T   = 20;
    localparam logic [7:0]  SOF = 8'h55;
`ifdef UART_CMD_ACK_EN
    localparam bit ACK_ON = 1'b1;
`else
    localparam bit ACK_ON = 1'b0;
`endif

    logic       clk_50m = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_done = 1'b0;
    logic [5:0] led;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;
    logic [7:0] ack_data;
    logic       ack_enable;

    uart_cmd_parser #(.SOF_BYTE(SOF), .TIMEOUT_CYC(T)) dut (
        .clk_50m     (clk_50m),
        .reset_n     (reset_n),
        .uart_rx_data(uart_rx_data),
        .uart_rx_done(uart_rx_done),
        .led         (led),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_arg     (cmd_arg),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .err_cnt     (err_cnt),
        .ack_data    (ack_data),
        .ack_enable  (ack_enable)
    );

    always #10 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [7:0] arg;
        logic [1:0] ecode;
        logic [5:0] led;
        logic [7:0] ecnt;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_none;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [5:0] m_led      = 6'h00;
    logic [7:0] m_err_cnt  = 8'h00;
    logic [1:0] m_err_code = 2'b00;

    bit         ack_pend = 1'b0;
    logic [7:0] ack_exp  = 8'h00;

    // Scoreboard: pops one expectation per strobe and checks the following-cycle acknowledge.
    always @(negedge clk_50m) begin
        exp_t       e;
        bit         ex_en;
        logic [7:0] ex_d;
        ex_en = ack_pend & ACK_ON;
        ex_d  = ack_exp;
        if (ex_en || ack_enable !== 1'b0) begin
            n_total++;
            if (ack_enable !== ex_en || (ex_en && ack_data !== ex_d))
                $display("FAIL ack: got en=%b data=%h, want en=%b data=%h", ack_enable, ack_data, ex_en, ex_d);
            else n_pass++;
        end
        ack_pend = 1'b0;
        if (reset_n && (cmd_valid === 1'b1 || frame_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: cmd_valid=%b frame_err=%b at cycle %0d, want none", cmd_valid, frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                n_total++;
                if ({cmd_valid, frame_err} !== {~e.is_err, e.is_err})
                    $display("FAIL strobe_kind: got cmd_valid=%b frame_err=%b, want %b %b", cmd_valid, frame_err, ~e.is_err, e.is_err);
                else n_pass++;
                n_total++;
                if (cyc != e.due) $display("FAIL latency: strobe at cycle %0d, want %0d", cyc, e.due);
                else n_pass++;
                n_total++;
                if (!e.is_err && {cmd_code, cmd_arg} !== {e.code, e.arg})
                    $display("FAIL cmd_fields: got %h/%h, want %h/%h", cmd_code, cmd_arg, e.code, e.arg);
                else if (e.is_err && err_code !== e.ecode)
                    $display("FAIL err_code: got %b, want %b", err_code, e.ecode);
                else n_pass++;
                n_total++;
                if (led !== e.led) $display("FAIL strobe_led: got %h, want %h", led, e.led);
                else n_pass++;
                n_total++;
                if (err_cnt !== e.ecnt) $display("FAIL strobe_err_cnt: got %h, want %h", err_cnt, e.ecnt);
                else n_pass++;
                ack_pend = 1'b1;
                ack_exp  = e.is_err ? (8'hE0 | {6'b0, e.ecode}) : (e.code | 8'h80);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap,
                             input bit push_en, input exp_t e_in, input int lat);
        exp_t e;
        @(negedge clk_50m);
        uart_rx_data = b;
        uart_rx_done = 1'b1;
        if (push_en) begin
            e     = e_in;
            e.due = cyc + lat;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk_50m);
        uart_rx_done = 1'b0;
        repeat (gap - 1) @(negedge clk_50m);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk, input int gap);
        exp_t       e;
        int         lat;
        logic [7:0] sum;
        sum      = cmd + arg;
        e.code   = cmd;
        e.arg    = arg;
        e.ecode  = 2'b00;
        e.due    = 0;
        e.is_err = 1'b0;
        lat      = 2;
        if (chk != sum) begin
            e.is_err = 1'b1;
            e.ecode  = 2'b01;
            lat      = 1;
        end else if (cmd == 8'h01) m_led = arg[5:0];
        else if (cmd == 8'h02)     m_led = m_led ^ arg[5:0];
        else if (cmd == 8'h03)     m_led = 6'h00;
        else begin
            e.is_err = 1'b1;
            e.ecode  = 2'b10;
        end
        if (e.is_err) begin
            m_err_code = e.ecode;
            if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
        end
        e.led  = m_led;
        e.ecnt = m_err_cnt;
        send_byte(SOF, 1, gap, 1'b0, e_none, 0);
        send_byte(cmd, 1, gap, 1'b0, e_none, 0);
        send_byte(arg, 1, gap, 1'b0, e_none, 0);
        send_byte(chk, 1, gap, 1'b1, e, lat);
    endtask

    function automatic exp_t timeout_exp();
        exp_t e;
        e.is_err   = 1'b1;
        e.code     = 8'h00;
        e.arg      = 8'h00;
        e.ecode    = 2'b11;
        m_err_code = 2'b11;
        if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
        e.led  = m_led;
        e.ecnt = m_err_cnt;
        e.due  = 0;
        return e;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        n_total++;
        if ({led, cmd_valid, cmd_code, cmd_arg, frame_err, err_code, err_cnt, ack_data, ack_enable} !== 43'h0)
            $display("FAIL reset_outputs: got led=%h cc=%h ca=%h ec=%b cnt=%h ack=%h/%b, want all 0",
                     led, cmd_code, cmd_arg, err_code, err_cnt, ack_data, ack_enable);
        else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        n_total++;
        if ({led, cmd_valid, frame_err, err_cnt} !== 16'h0)
            $display("FAIL post_reset_idle: got led=%h cv=%b fe=%b cnt=%h, want 0", led, cmd_valid, frame_err, err_cnt);
        else n_pass++;
    endtask

    task automatic test_load;
        send_frame(8'h01, 8'h2A, 8'h2B, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL load_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        n_total++;
        if (led !== 6'h2A) $display("FAIL load_led: got %h, want 2a", led);
        else n_pass++;
        n_total++;
        if (err_cnt !== 8'h00) $display("FAIL load_err_cnt: got %h, want 00", err_cnt);
        else n_pass++;
    endtask

    task automatic test_xor_clear;
        send_frame(8'h02, 8'h03, 8'h05, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h29) $display("FAIL xor_led: got %h, want 29", led);
        else n_pass++;
        send_frame(8'h03, 8'h00, 8'h03, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h00) $display("FAIL clear_led: got %h, want 00", led);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL xor_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_errors;
        send_frame(8'h01, 8'h2A, 8'h2B, 2);
        send_frame(8'h01, 8'h2A, 8'h00, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if ({led, err_code, err_cnt} !== {6'h2A, 2'b01, 8'h01})
            $display("FAIL chk_err_state: got led=%h ec=%b cnt=%h, want 2a 01 01", led, err_code, err_cnt);
        else n_pass++;
        send_frame(8'h07, 8'h00, 8'h07, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if ({led, err_code, err_cnt, cmd_code, cmd_arg} !== {6'h2A, 2'b10, 8'h02, 8'h01, 8'h2A})
            $display("FAIL unknown_cmd_state: got led=%h ec=%b cnt=%h cc=%h ca=%h, want 2a 10 02 01 2a",
                     led, err_code, err_cnt, cmd_code, cmd_arg);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL errors_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_timeout;
        exp_t e;
        send_byte(SOF, 1, 2, 1'b0, e_none, 0);
        e = timeout_exp();
        send_byte(8'h01, 1, 2, 1'b1, e, T + 1);
        repeat (T + 4) @(negedge clk_50m);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL timeout_missing: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        n_total++;
        if ({err_code, err_cnt} !== {2'b11, 8'h03}) $display("FAIL timeout_state: got ec=%b cnt=%h, want 11 03", err_code, err_cnt);
        else n_pass++;
        send_frame(8'h01, 8'h15, 8'h16, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h15) $display("FAIL timeout_recover_led: got %h, want 15", led);
        else n_pass++;
    endtask

    task automatic test_timeout_boundary;
        exp_t e;
        // CMD byte lands on the last counter value: the byte wins, no timeout.
        send_byte(SOF, 1, 1, 1'b0, e_none, 0);
        repeat (T - 2) @(negedge clk_50m);
        send_byte(8'h01, 1, 2, 1'b0, e_none, 0);
        send_byte(8'h33, 1, 2, 1'b0, e_none, 0);
        m_led    = 6'h33;
        e.is_err = 1'b0;
        e.code   = 8'h01;
        e.arg    = 8'h33;
        e.ecode  = 2'b00;
        e.led    = m_led;
        e.ecnt   = m_err_cnt;
        send_byte(8'h34, 1, 2, 1'b1, e, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h33) $display("FAIL tmo_edge_led: got %h, want 33", led);
        else n_pass++;
        // One cycle later the timeout has fired and the late byte lands in IDLE.
        e = timeout_exp();
        send_byte(SOF, 1, 1, 1'b1, e, T + 1);
        repeat (T - 1) @(negedge clk_50m);
        send_byte(8'h01, 1, 2, 1'b0, e_none, 0);
        repeat (4) @(negedge clk_50m);
        send_frame(8'h01, 8'h3C, 8'h3D, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if ({led, err_cnt} !== {6'h3C, 8'h04}) $display("FAIL tmo_late_state: got led=%h cnt=%h, want 3c 04", led, err_cnt);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL tmo_edge_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset_midframe;
        exp_t e;
        send_byte(SOF, 1, 2, 1'b0, e_none, 0);
        send_byte(8'h01, 1, 2, 1'b0, e_none, 0);
        reset_n = 1'b0;
        #2;
        n_total++;
        if ({led, cmd_code, cmd_arg, err_code, err_cnt} !== 32'h0)
            $display("FAIL midframe_reset: got led=%h cc=%h ca=%h ec=%b cnt=%h, want 0", led, cmd_code, cmd_arg, err_code, err_cnt);
        else n_pass++;
        m_led      = 6'h00;
        m_err_cnt  = 8'h00;
        m_err_code = 2'b00;
        repeat (2) @(negedge clk_50m);
        reset_n = 1'b1;
        send_byte(8'h2A, 1, 2, 1'b0, e_none, 0);
        send_byte(8'h2B, 1, 2, 1'b0, e_none, 0);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h00) $display("FAIL orphan_bytes_led: got %h, want 00", led);
        else n_pass++;
        // Long uart_rx_done pulses must each count as a single byte.
        send_byte(SOF, 10, 2, 1'b0, e_none, 0);
        send_byte(8'h01, 1, 2, 1'b0, e_none, 0);
        send_byte(8'h2A, 10, 2, 1'b0, e_none, 0);
        m_led    = 6'h2A;
        e.is_err = 1'b0;
        e.code   = 8'h01;
        e.arg    = 8'h2A;
        e.ecode  = 2'b00;
        e.led    = m_led;
        e.ecnt   = m_err_cnt;
        send_byte(8'h2B, 10, 2, 1'b1, e, 2);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (led !== 6'h2A) $display("FAIL long_pulse_led: got %h, want 2a", led);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL long_pulse_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_back_to_back;
        send_frame(8'h01, 8'h3F, 8'h40, 1);
        send_frame(8'h02, 8'h15, 8'h17, 1);
        send_frame(8'h03, 8'h00, 8'h03, 1);
        send_frame(8'h01, 8'h0A, 8'h0B, 1);
        send_frame(8'h04, 8'h01, 8'h05, 1);
        send_frame(8'h02, 8'h55, 8'h57, 1);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if ({led, err_cnt} !== {6'h1F, 8'h01}) $display("FAIL b2b_state: got led=%h cnt=%h, want 1f 01", led, err_cnt);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_err_saturation;
        for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h00, 8'hFF, 1);
        repeat (4) @(negedge clk_50m);
        n_total++;
        if (err_cnt !== 8'hFF) $display("FAIL err_cnt_saturate: got %h, want ff", err_cnt);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL sat_outstanding: %0d strobes missing, want 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_xor_clear();
        test_errors();
        test_timeout();
        test_timeout_boundary();
        test_reset_midframe();
        test_back_to_back();
        test_err_saturation();
        repeat (3) @(negedge clk_50m);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
